// File: rtl/ps2_cmd_pkg.sv
// Shared scan codes, command encodings and decoder state type for the
// PS/2 command sequencer.
package ps2_cmd_pkg;

    localparam logic [7:0] SC_HIT   = 8'h33;
    localparam logic [7:0] SC_STAND = 8'h1B;
    localparam logic [7:0] SC_DEAL  = 8'h23;
    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;

    typedef enum logic [1:0] {
        CMD_NONE  = 2'd0,
        CMD_HIT   = 2'd1,
        CMD_STAND = 2'd2,
        CMD_DEAL  = 2'd3
    } cmd_t;

    typedef enum logic [1:0] {
        IDLE,
        BRK,
        EXT,
        EXT_BRK
    } state_t;

    function automatic logic [2:0] key_mask(input logic [7:0] code);
        case (code)
            SC_HIT:   return 3'b001;
            SC_STAND: return 3'b010;
            SC_DEAL:  return 3'b100;
            default:  return 3'b000;
        endcase
    endfunction

    function automatic cmd_t key_cmd(input logic [7:0] code);
        case (code)
            SC_HIT:   return CMD_HIT;
            SC_STAND: return CMD_STAND;
            SC_DEAL:  return CMD_DEAL;
            default:  return CMD_NONE;
        endcase
    endfunction

endpackage

// File: rtl/ps2_cmd_fifo.sv
// Synchronous command queue; head reads as zero while empty.
module ps2_cmd_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [1:0]             push_data,
    input  logic                   pop,
    output logic                   valid,
    output logic                   full,
    output logic [1:0]             head_data,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count_q;
    logic [1:0]    mem [DEPTH];
    logic          do_push;
    logic          do_pop;

    assign valid     = (count_q != '0);
    assign full      = (count_q == CW'(DEPTH));
    assign do_pop    = pop && valid;
    // A full queue still accepts a push when the head leaves this cycle
    assign do_push   = push && (!full || do_pop);
    assign head_data = valid ? mem[rd_ptr] : 2'b00;
    assign count     = count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/ps2_cmd_sequencer.sv
// PS/2 scan-code decoder that queues HIT/STAND/DEAL commands.
// Optional partial-sequence watchdog: define PS2_CMD_TIMEOUT_EN.
module ps2_cmd_sequencer
    import ps2_cmd_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 5_000_000
) (
    input  logic                        CLOCK_50,
    input  logic                        reset,
    input  logic [7:0]                  received_data,
    input  logic                        received_data_en,
    input  logic                        cmd_ready,
    output logic                        cmd_valid,
    output logic [1:0]                  cmd_code,
    output logic [2:0]                  key_held,
    output logic                        overflow,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of 2 and at least 2");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    state_t     state_q, state_d;
    logic [2:0] held_q, held_d;
    logic       ovf_q, ovf_d;
    logic       push;
    cmd_t       push_code;
    logic [2:0] mask;
    logic       fifo_full;
    logic       pop;

`ifdef PS2_CMD_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    logic [WW-1:0] wdog_q, wdog_d;
`endif

    assign pop      = cmd_valid && cmd_ready;
    assign mask     = key_mask(received_data);
    assign key_held = held_q;
    assign overflow = ovf_q;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q <= IDLE;
            held_q  <= '0;
            ovf_q   <= 1'b0;
`ifdef PS2_CMD_TIMEOUT_EN
            wdog_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            held_q  <= held_d;
            ovf_q   <= ovf_d;
`ifdef PS2_CMD_TIMEOUT_EN
            wdog_q  <= wdog_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        held_d    = held_q;
        push      = 1'b0;
        push_code = CMD_NONE;
`ifdef PS2_CMD_TIMEOUT_EN
        wdog_d    = '0;
`endif
        if (received_data_en) begin
            state_d = IDLE;
            unique case (state_q)
                IDLE: begin
                    if (received_data == SC_BREAK) begin
                        state_d = BRK;
                    end else if (received_data == SC_EXT) begin
                        state_d = EXT;
                    end else if (mask != '0 && (held_q & mask) == '0) begin
                        held_d    = held_q | mask;
                        push      = 1'b1;
                        push_code = key_cmd(received_data);
                    end
                end
                BRK: held_d = held_q & ~mask;
                EXT: begin
                    if (received_data == SC_BREAK) state_d = EXT_BRK;
                end
                EXT_BRK: state_d = IDLE;
            endcase
        end
`ifdef PS2_CMD_TIMEOUT_EN
        else if (state_q != IDLE) begin
            // Abandon a half-received sequence after a long silence
            if (wdog_q == WW'(TIMEOUT_CYCLES - 1)) state_d = IDLE;
            else wdog_d = wdog_q + WW'(1);
        end
`endif
        ovf_d = ovf_q | (push && fifo_full && !pop);
    end

    ps2_cmd_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk       (CLOCK_50),
        .reset     (reset),
        .push      (push),
        .push_data (push_code),
        .pop       (pop),
        .valid     (cmd_valid),
        .full      (fifo_full),
        .head_data (cmd_code),
        .count     (fifo_count)
    );

endmodule

// File: doc/ps2_cmd_sequencer.md
PS2_CMD_SEQUENCER -- requirements
Module: ps2_cmd_sequencer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4: command queue entries; power of 2, at least 2.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 5_000_000: partial-sequence watchdog limit (100 ms at 50 MHz).
REQ-003 SHALL have port CLOCK_50, input, 1: sole clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port received_data, input, 8: PS/2 scan-code byte from the PS/2 controller.
REQ-006 SHALL have port received_data_en, input, 1: one-cycle strobe; received_data valid this cycle.
REQ-007 SHALL have port cmd_ready, input, 1: game FSM accepts the head command.
REQ-008 SHALL have port cmd_valid, output, 1: queue non-empty.
REQ-009 SHALL have port cmd_code, output, 2: head command; 1=HIT, 2=STAND, 3=DEAL, 0 never emitted while cmd_valid=1.
REQ-010 SHALL have port key_held, output, 3: bit0 H, bit1 S, bit2 D currently pressed.
REQ-011 SHALL have port overflow, output, 1: sticky; a command was dropped.
REQ-012 SHALL have port fifo_count, output, $clog2(FIFO_DEPTH)+1: entries queued.

Function
REQ-013 SHALL decode with a 4-state FSM: IDLE, BRK (after F0), EXT (after E0), EXT_BRK (after E0 F0).
REQ-014 SHALL apply these transitions only on received_data_en=1: IDLE--F0->BRK, IDLE--E0->EXT, EXT--F0->EXT_BRK; any other byte returns the FSM to IDLE after processing.
REQ-015 SHALL, in IDLE, on byte 0x33/0x1B/0x23 with key_held bit=0, set the bit and push HIT/STAND/DEAL respectively.
REQ-016 SHALL, in IDLE, ignore a make code whose key_held bit is already 1 (typematic repeat; no push).
REQ-017 SHALL, in BRK, clear the key_held bit for 0x33/0x1B/0x23; other bytes have no effect.
REQ-018 SHALL consume but ignore extended make and break bytes (EXT, EXT_BRK); no push, no key_held change.
REQ-019 SHALL push at most one command per strobe; push latency is 1 cycle (cmd_valid high the cycle after the strobe when the queue was empty).
REQ-020 SHALL pop the head on the cycle where cmd_valid && cmd_ready; cmd_code SHALL be held stable while cmd_valid=1 and cmd_ready=0.
REQ-021 SHALL, on push while full without a same-cycle pop, drop the command, set overflow, and leave the queue unchanged; key_held still updates.
REQ-022 SHALL, on simultaneous push and pop while full, accept the push; fifo_count stays FIFO_DEPTH.
REQ-023 SHALL, on simultaneous push and pop while empty, pass the command through the queue (no bypass); cmd_valid asserts next cycle.
REQ-024 SHALL wrap queue pointers modulo FIFO_DEPTH; fifo_count SHALL never exceed FIFO_DEPTH.

Reset
REQ-025 SHALL, on reset=1 at a clock edge, force FSM=IDLE, queue empty, cmd_valid=0, cmd_code=0, key_held=0, overflow=0, fifo_count=0, watchdog=0.
REQ-026 SHALL give reset priority over any simultaneous strobe or pop; a sequence in progress is discarded.

Configuration
REQ-027 SHALL, with PS2_CMD_TIMEOUT_EN defined, count cycles spent in BRK/EXT/EXT_BRK and return to IDLE with no side effects when the count reaches TIMEOUT_CYCLES without a strobe; any strobe restarts the count.
REQ-028 SHALL, without PS2_CMD_TIMEOUT_EN, omit the watchdog counter entirely; the FSM leaves non-IDLE states only on a strobe.

Structure
REQ-029 SHALL place scan-code constants (0x33, 0x1B, 0x23, 0xF0, 0xE0), command encodings, and the FSM state type in shared package ps2_cmd_pkg.
REQ-030 SHALL implement the queue as sub-module ps2_cmd_fifo (synchronous, FIFO_DEPTH-parameterised, count output).

Verification
REQ-031 SHALL cover: strobe 0x33 with cmd_ready=0 -> next cycle cmd_valid=1, cmd_code=1, key_held=3'b001.
REQ-032 SHALL cover: 0x1B, 0x1B, 0x1B, then F0 1B, then 0x1B -> exactly two STAND (code 2) commands queued; key_held[1]=1 at the end.
REQ-033 SHALL cover: cmd_ready=0 and five distinct make/break HIT presses -> fifo_count=4, overflow=1; draining yields four HIT commands.
REQ-034 SHALL cover: E0 33 then E0 F0 33 -> no command; key_held=0; FSM ends in IDLE.
REQ-035 SHALL cover: F0 then 5_000_000 idle cycles (macro defined), then 0x23 -> DEAL pushed; with the macro undefined, the same 0x23 is treated as a break (no push).
REQ-036 SHALL cover: reset asserted while full with key_held=3'b111 -> next cycle every output is 0.
